// File: rtl/naive_bus_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : naive_bus_timer_pkg
// Purpose : Shared definitions for the naive_bus machine timer: register
//           word indices (addr[4:2]), ctrl bit positions, the 64-bit timer
//           type and a byte-enable merge helper. Software header generation
//           consumes this package too, so the register indices here are the
//           single source of truth for the memory map (byte offset = idx*4).
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package naive_bus_timer_pkg;

  // 64-bit timer value (mtime / mtimecmp)
  typedef logic [63:0] timer_t;

  // Register word index taken from addr[4:2]; indices 6 and 7 are unmapped
  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,  // 0x00
    REG_MTIME_HI = 3'd1,  // 0x04
    REG_CMP_LO   = 3'd2,  // 0x08
    REG_CMP_HI   = 3'd3,  // 0x0C
    REG_CTRL     = 3'd4,  // 0x10
    REG_PRESC    = 3'd5   // 0x14
  } reg_idx_e;

  // ctrl register bit positions
  localparam int unsigned CTRL_ENABLE_BIT  = 0;
  localparam int unsigned CTRL_PENDING_BIT = 1;

  // Merge a 32-bit write into an existing word, one byte per enable bit
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/naive_bus.sv
`default_nettype none
// ============================================================================
// Module  : naive_bus (interface)
// Purpose : Simple split read/write bus used by the core for instruction and
//           data accesses. Requests are granted in the same cycle by gnt;
//           read data returns one cycle after a granted read.
// Signals : rd_req/rd_gnt/rd_addr/rd_data  - read channel
//           wr_req/wr_gnt/wr_addr/wr_data/wr_be - write channel
// Modports: master (requester), slave (responder)
// Rev     : 1.0 - initial release
// ============================================================================
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface
`default_nettype wire

// File: rtl/naive_bus_timer_presc.sv
`default_nettype none
// ============================================================================
// Module  : naive_bus_timer_presc
// Purpose : Reload down-counter that paces the timer. tick_o is high while
//           the counter is 0; on an enabled cycle the counter then reloads,
//           otherwise it decrements. A reload value of 0 ticks every cycle.
//           Only instantiated when NAIVE_BUS_TIMER_PRESC_EN is defined.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           en_i       - count enable (counter holds when low)
//           load_i     - force reload from reload_i this edge
//           reload_i   - reload value (PRESC_W bits)
//           tick_o     - prescaler tick
// Rev     : 1.0 - initial release
// ============================================================================
module naive_bus_timer_presc #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               load_i,
  input  logic [PRESC_W-1:0] reload_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      // A new reload value restarts the period immediately
      cnt_d = reload_i;
    end else if (en_i) begin
      cnt_d = tick_o ? reload_i : (cnt_q - PRESC_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/naive_bus_timer.sv
`default_nettype none
// ============================================================================
// Module  : naive_bus_timer
// Purpose : Memory-mapped 64-bit machine timer on the naive_bus responder
//           side. Registers (addr[4:2]): mtime_lo, mtime_hi, cmp_lo, cmp_hi,
//           ctrl {pending, enable}, presc. Reading mtime_lo snapshots
//           mtime[63:32] so a following mtime_hi read is coherent.
//           irq is the level of ctrl.pending.
// Macro   : NAIVE_BUS_TIMER_PRESC_EN - when defined, a reload prescaler paces
//           the counter and presc is writable; when undefined, the timer
//           ticks every enabled cycle and presc reads 0.
// Ports   : clk  - clock
//           rst  - synchronous active-high reset
//           bus  - naive_bus.slave responder port
//           irq  - level timer interrupt
// Rev     : 1.0 - initial release
// ============================================================================
module naive_bus_timer
  import naive_bus_timer_pkg::*;
#(
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic     clk,
  input  logic     rst,
  naive_bus.slave  bus,
  output logic     irq
);

  if (PRESC_W == 0 || PRESC_W > 32) begin : g_presc_w_check
    $error("naive_bus_timer: PRESC_W must be in 1..32");
  end

  reg_idx_e    rd_idx, wr_idx;
  logic        wr_act;
  logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
  logic        ctrl_wr_lsb;
  logic        tick, inc, cmp_hit;
  timer_t      mtime_q, mtime_d, cmp_q, cmp_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] rd_data_q, rd_data_d, rd_mux;
  logic        enable_q, enable_d, pending_q, pending_d;
  logic        unused_bits;

  // The responder never stalls
  assign bus.rd_gnt  = bus.rd_req;
  assign bus.wr_gnt  = bus.wr_req;
  assign bus.rd_data = rd_data_q;
  assign irq         = pending_q;

  // Only the word index is decoded; other address bits alias
  assign rd_idx = reg_idx_e'(bus.rd_addr[4:2]);
  assign wr_idx = reg_idx_e'(bus.wr_addr[4:2]);
  assign unused_bits = ^{bus.rd_addr[31:5], bus.rd_addr[1:0],
                         bus.wr_addr[31:5], bus.wr_addr[1:0]};

  // A write with no byte enables is a no-op (and must not block counting)
  assign wr_act      = bus.wr_req && (bus.wr_be != 4'b0000);
  assign wr_mtime_lo = wr_act && (wr_idx == REG_MTIME_LO);
  assign wr_mtime_hi = wr_act && (wr_idx == REG_MTIME_HI);
  assign wr_cmp_lo   = wr_act && (wr_idx == REG_CMP_LO);
  assign wr_cmp_hi   = wr_act && (wr_idx == REG_CMP_HI);
  assign wr_ctrl     = wr_act && (wr_idx == REG_CTRL);
  assign ctrl_wr_lsb = wr_ctrl && bus.wr_be[0];

`ifdef NAIVE_BUS_TIMER_PRESC_EN
  logic               wr_presc;
  logic [PRESC_W-1:0] presc_q, presc_d;

  assign wr_presc = wr_act && (wr_idx == REG_PRESC);

  for (genvar gi = 0; gi < int'(PRESC_W); gi++) begin : g_presc_bit
    assign presc_d[gi] = (wr_presc && bus.wr_be[gi / 8]) ? bus.wr_data[gi]
                                                         : presc_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  // presc_d equals presc_q unless written, so it doubles as the reload value
  naive_bus_timer_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk      (clk),
    .rst      (rst),
    .en_i     (enable_q),
    .load_i   (wr_presc),
    .reload_i (presc_d),
    .tick_o   (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign inc     = enable_q && tick;
  assign cmp_hit = enable_q && (mtime_q >= cmp_q);

  // mtime: a written half wins over the increment and the other half holds
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mtime_lo) begin
      mtime_d[31:0] = be_merge(mtime_q[31:0], bus.wr_data, bus.wr_be);
    end else if (wr_mtime_hi) begin
      mtime_d[63:32] = be_merge(mtime_q[63:32], bus.wr_data, bus.wr_be);
    end else if (inc) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (wr_cmp_lo) cmp_d[31:0]  = be_merge(cmp_q[31:0], bus.wr_data, bus.wr_be);
    if (wr_cmp_hi) cmp_d[63:32] = be_merge(cmp_q[63:32], bus.wr_data, bus.wr_be);
  end

  // pending: set has priority over the write-one-to-clear
  always_comb begin
    enable_d  = ctrl_wr_lsb ? bus.wr_data[CTRL_ENABLE_BIT] : enable_q;
    pending_d = pending_q;
    if (cmp_hit) begin
      pending_d = 1'b1;
    end else if (ctrl_wr_lsb && bus.wr_data[CTRL_PENDING_BIT]) begin
      pending_d = 1'b0;
    end
  end

  // Read mux uses pre-write state, so a same-cycle write is not visible
  always_comb begin
    rd_mux = 32'h0;
    case (rd_idx)
      REG_MTIME_LO: rd_mux = mtime_q[31:0];
      REG_MTIME_HI: rd_mux = hi_shadow_q;
      REG_CMP_LO:   rd_mux = cmp_q[31:0];
      REG_CMP_HI:   rd_mux = cmp_q[63:32];
      REG_CTRL: begin
        rd_mux[CTRL_ENABLE_BIT]  = enable_q;
        rd_mux[CTRL_PENDING_BIT] = pending_q;
      end
      REG_PRESC: begin
`ifdef NAIVE_BUS_TIMER_PRESC_EN
        rd_mux = 32'(presc_q);
`else
        rd_mux = 32'h0;
`endif
      end
      default: rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    rd_data_d   = bus.rd_req ? rd_mux : rd_data_q;
    hi_shadow_d = (bus.rd_req && (rd_idx == REG_MTIME_LO)) ? mtime_q[63:32]
                                                           : hi_shadow_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q     <= '0;
      hi_shadow_q <= '0;
      cmp_q       <= CMP_RESET;
      enable_q    <= 1'b0;
      pending_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      mtime_q     <= mtime_d;
      hi_shadow_q <= hi_shadow_d;
      cmp_q       <= cmp_d;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      rd_data_q   <= rd_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_naive_bus_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_naive_bus_timer
// Purpose : Directed self-checking bench for naive_bus_timer. Inputs change
//           1 time unit after each rising edge; outputs are sampled there.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_naive_bus_timer;

`ifdef NAIVE_BUS_TIMER_PRESC_EN
  localparam bit PRESC_ON = 1'b1;
`else
  localparam bit PRESC_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        irq;
  logic [31:0] rd;
  int          n_pass;
  int          n_total;

  naive_bus bus_if ();

  naive_bus_timer #(
    .CMP_RESET (64'hFFFF_FFFF_FFFF_FFFF),
    .PRESC_W   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .irq (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    bus_if.rd_req  = 1'b1;
    bus_if.rd_addr = a;
    tick();
    bus_if.rd_req  = 1'b0;
    d = bus_if.rd_data;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    bus_if.wr_req  = 1'b1;
    bus_if.wr_addr = a;
    bus_if.wr_data = d;
    bus_if.wr_be   = be;
    tick();
    bus_if.wr_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.rd_req = 1'b1; bus_if.rd_addr = 32'h08;
    bus_if.wr_req = 1'b1; bus_if.wr_addr = 32'h10;
    bus_if.wr_data = 32'h1; bus_if.wr_be = 4'b0001;
    tick();
    tick();
    n_total++;
    if (bus_if.rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h expected %h", bus_if.rd_data, 32'h0);
    else n_pass++;
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
    else n_pass++;
    bus_if.rd_req = 1'b0; bus_if.wr_req = 1'b0;
    rst = 1'b0;
    do_read(32'h00, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL reset_mtime_lo: got %h expected %h", rd, 32'h0);
    else n_pass++;
    do_read(32'h08, rd);
    n_total++;
    if (rd !== 32'hFFFF_FFFF) $display("FAIL reset_cmp_lo: got %h expected %h", rd, 32'hFFFF_FFFF);
    else n_pass++;
    do_read(32'h0C, rd);
    n_total++;
    if (rd !== 32'hFFFF_FFFF) $display("FAIL reset_cmp_hi: got %h expected %h", rd, 32'hFFFF_FFFF);
    else n_pass++;
    do_read(32'h10, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL reset_ctrl: got %h expected %h", rd, 32'h0);
    else n_pass++;
  endtask

  task automatic test_count();
    do_write(32'h10, 32'h1, 4'b0001);   // enable, no increment this edge
    repeat (10) tick();
    do_read(32'h00, rd);
    n_total++;
    if (rd !== 32'd10) $display("FAIL count_lo: got %0d expected %0d", rd, 10);
    else n_pass++;
    do_read(32'h04, rd);
    n_total++;
    if (rd !== 32'd0) $display("FAIL count_hi: got %h expected %h", rd, 32'h0);
    else n_pass++;
    do_read(32'h00, rd);
    n_total++;
    if (rd !== 32'd12) $display("FAIL count_lo_again: got %0d expected %0d", rd, 12);
    else n_pass++;
    tick();
    n_total++;
    if (bus_if.rd_data !== 32'd12) $display("FAIL rd_data_hold: got %0d expected %0d", bus_if.rd_data, 12);
    else n_pass++;
    do_write(32'h10, 32'h0, 4'b0001);
  endtask

  task automatic test_shadow();
    do_write(32'h00, 32'hFFFF_FFFF, 4'hF);
    do_write(32'h04, 32'h0, 4'hF);
    do_write(32'h10, 32'h1, 4'b0001);   // mtime = 0x0_FFFFFFFF
    tick();                             // -> 0x1_00000000
    do_read(32'h00, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL shadow_lo: got %h expected %h", rd, 32'h0);
    else n_pass++;
    do_read(32'h04, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL shadow_hi: got %h expected %h", rd, 32'h1);
    else n_pass++;
    do_write(32'h10, 32'h0, 4'b0001);   // mtime = 0x1_00000003 after
    do_write(32'h04, 32'hDEAD_BEEF, 4'hF);
    do_read(32'h04, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL shadow_not_live: got %h expected %h", rd, 32'h1);
    else n_pass++;
    do_read(32'h00, rd);
    n_total++;
    if (rd !== 32'h3) $display("FAIL shadow_lo2: got %h expected %h", rd, 32'h3);
    else n_pass++;
    do_read(32'h04, rd);
    n_total++;
    if (rd !== 32'hDEAD_BEEF) $display("FAIL shadow_hi2: got %h expected %h", rd, 32'hDEAD_BEEF);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_write(32'h00, 32'hFFFF_FFFF, 4'hF);
    do_write(32'h04, 32'hFFFF_FFFF, 4'hF);
    do_write(32'h10, 32'h1, 4'b0001);
    n_total++;
    if (irq !== 1'b0) $display("FAIL wrap_irq_pre: got %b expected 0", irq);
    else n_pass++;
    tick();   // mtime == cmp (all ones) was seen while enabled; wraps to 0
    n_total++;
    if (irq !== 1'b1) $display("FAIL wrap_irq_equal: got %b expected 1", irq);
    else n_pass++;
    do_read(32'h00, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL wrap_lo: got %h expected %h", rd, 32'h0);
    else n_pass++;
    do_read(32'h04, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL wrap_hi: got %h expected %h", rd, 32'h0);
    else n_pass++;
    do_write(32'h10, 32'h2, 4'b0001);   // clear pending, disable
    n_total++;
    if (irq !== 1'b0) $display("FAIL wrap_w1c: got %b expected 0", irq);
    else n_pass++;
  endtask

  task automatic test_partial_write();
    do_write(32'h00, 32'h1234_55FE, 4'hF);
    do_write(32'h04, 32'h0, 4'hF);
    do_write(32'h10, 32'h1, 4'b0001);
    tick();
    tick();                              // mtime_lo = 0x12345600
    do_write(32'h00, 32'h0000_00AB, 4'b0001);
    do_read(32'h00, rd);
    n_total++;
    if (rd !== 32'h1234_56AB) $display("FAIL partial_lo: got %h expected %h", rd, 32'h1234_56AB);
    else n_pass++;
    do_write(32'h10, 32'h0, 4'b0001);   // mtime_lo = 0x123456AD after
    do_write(32'h00, 32'h0, 4'b0000);
    do_read(32'h00, rd);
    n_total++;
    if (rd !== 32'h1234_56AD) $display("FAIL be_zero: got %h expected %h", rd, 32'h1234_56AD);
    else n_pass++;
    do_write(32'h04, 32'hAA55_1234, 4'b1000);
    do_read(32'h00, rd);
    do_read(32'h04, rd);
    n_total++;
    if (rd !== 32'hAA00_0000) $display("FAIL partial_hi: got %h expected %h", rd, 32'hAA00_0000);
    else n_pass++;
  endtask

  task automatic test_compare();
    do_write(32'h00, 32'h0, 4'hF);
    do_write(32'h04, 32'h0, 4'hF);
    do_write(32'h08, 32'd20, 4'hF);
    do_write(32'h0C, 32'h0, 4'hF);
    do_write(32'h10, 32'h1, 4'b0001);
    repeat (20) tick();                  // mtime reaches 20
    n_total++;
    if (irq !== 1'b0) $display("FAIL cmp_irq_early: got %b expected 0", irq);
    else n_pass++;
    tick();
    n_total++;
    if (irq !== 1'b1) $display("FAIL cmp_irq_rise: got %b expected 1", irq);
    else n_pass++;
    do_write(32'h10, 32'h3, 4'b0001);
    n_total++;
    if (irq !== 1'b1) $display("FAIL cmp_set_wins: got %b expected 1", irq);
    else n_pass++;
    do_write(32'h08, 32'hFFFF_FFFF, 4'hF);
    do_write(32'h0C, 32'hFFFF_FFFF, 4'hF);
    n_total++;
    if (irq !== 1'b1) $display("FAIL cmp_irq_held: got %b expected 1", irq);
    else n_pass++;
    do_write(32'h10, 32'h3, 4'b0001);
    n_total++;
    if (irq !== 1'b0) $display("FAIL cmp_w1c: got %b expected 0", irq);
    else n_pass++;
    do_read(32'h10, rd);
    n_total++;
    if (rd !== 32'h1) $display("FAIL cmp_ctrl_read: got %h expected %h", rd, 32'h1);
    else n_pass++;
    do_write(32'h10, 32'h0, 4'b0001);
  endtask

  task automatic test_presc();
    do_write(32'h00, 32'h0, 4'hF);
    do_write(32'h04, 32'h0, 4'hF);
    do_write(32'h14, 32'h3, 4'hF);
    do_write(32'h10, 32'h1, 4'b0001);
    repeat (7) tick();
    do_read(32'h00, rd);
    n_total++;
    if (rd !== (PRESC_ON ? 32'd1 : 32'd7)) $display("FAIL presc_cnt1: got %0d expected %0d", rd, (PRESC_ON ? 1 : 7));
    else n_pass++;
    repeat (3) tick();
    do_read(32'h00, rd);
    n_total++;
    if (rd !== (PRESC_ON ? 32'd2 : 32'd11)) $display("FAIL presc_cnt2: got %0d expected %0d", rd, (PRESC_ON ? 2 : 11));
    else n_pass++;
    do_read(32'h14, rd);
    n_total++;
    if (rd !== (PRESC_ON ? 32'd3 : 32'd0)) $display("FAIL presc_read: got %h expected %h", rd, (PRESC_ON ? 32'd3 : 32'd0));
    else n_pass++;
    do_write(32'h10, 32'h0, 4'b0001);
    do_write(32'h14, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back();
    do_write(32'h08, 32'h1111_1111, 4'hF);
    bus_if.rd_req = 1'b1; bus_if.rd_addr = 32'h08;
    bus_if.wr_req = 1'b1; bus_if.wr_addr = 32'h08;
    bus_if.wr_data = 32'h2222_2222; bus_if.wr_be = 4'hF;
    #1;
    n_total++;
    if (bus_if.rd_gnt !== 1'b1 || bus_if.wr_gnt !== 1'b1)
      $display("FAIL gnt_comb: got %b%b expected 11", bus_if.rd_gnt, bus_if.wr_gnt);
    else n_pass++;
    tick();
    bus_if.rd_req = 1'b0; bus_if.wr_req = 1'b0;
    n_total++;
    if (bus_if.rd_data !== 32'h1111_1111) $display("FAIL rw_same_old: got %h expected %h", bus_if.rd_data, 32'h1111_1111);
    else n_pass++;
    do_read(32'h08, rd);
    n_total++;
    if (rd !== 32'h2222_2222) $display("FAIL rw_same_new: got %h expected %h", rd, 32'h2222_2222);
    else n_pass++;
    // Build non-reset state: cmp=0, mtime_hi=7 captured in shadow, pending
    do_write(32'h0C, 32'h0, 4'hF);
    do_write(32'h08, 32'h0, 4'hF);
    do_write(32'h04, 32'h7, 4'hF);
    do_read(32'h00, rd);
    do_write(32'h10, 32'h1, 4'b0001);
    tick();
    n_total++;
    if (irq !== 1'b1) $display("FAIL pre_reset_irq: got %b expected 1", irq);
    else n_pass++;
    do_write(32'h14, 32'h5, 4'hF);
    // Reset with back-to-back bus traffic
    rst = 1'b1;
    bus_if.rd_req = 1'b1; bus_if.rd_addr = 32'h08;
    bus_if.wr_req = 1'b1; bus_if.wr_addr = 32'h0C;
    bus_if.wr_data = 32'h5; bus_if.wr_be = 4'hF;
    tick();
    n_total++;
    if (bus_if.rd_data !== 32'h0 || irq !== 1'b0)
      $display("FAIL rst_mid: got rd_data=%h irq=%b expected 0/0", bus_if.rd_data, irq);
    else n_pass++;
    bus_if.rd_addr = 32'h10; bus_if.wr_addr = 32'h10;
    bus_if.wr_data = 32'h1; bus_if.wr_be = 4'b0001;
    tick();
    bus_if.rd_req = 1'b0; bus_if.wr_req = 1'b0;
    #1;
    n_total++;
    if (bus_if.rd_gnt !== 1'b0 || bus_if.rd_data !== 32'h0)
      $display("FAIL rst_gnt: got gnt=%b rd_data=%h expected 0/0", bus_if.rd_gnt, bus_if.rd_data);
    else n_pass++;
    rst = 1'b0;
    do_read(32'h04, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL rst_shadow: got %h expected %h", rd, 32'h0);
    else n_pass++;
    do_read(32'h00, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL rst_mtime: got %h expected %h", rd, 32'h0);
    else n_pass++;
    do_read(32'h0C, rd);
    n_total++;
    if (rd !== 32'hFFFF_FFFF) $display("FAIL rst_cmp_hi: got %h expected %h", rd, 32'hFFFF_FFFF);
    else n_pass++;
    do_read(32'h10, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL rst_ctrl: got %h expected %h", rd, 32'h0);
    else n_pass++;
    do_read(32'h14, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL rst_presc: got %h expected %h", rd, 32'h0);
    else n_pass++;
    do_read(32'h1C, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL unmapped_1c: got %h expected %h", rd, 32'h0);
    else n_pass++;
    do_write(32'h18, 32'hFFFF_FFFF, 4'hF);
    do_read(32'h18, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL unmapped_18: got %h expected %h", rd, 32'h0);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    bus_if.rd_req  = 1'b0;
    bus_if.rd_addr = 32'h0;
    bus_if.wr_req  = 1'b0;
    bus_if.wr_addr = 32'h0;
    bus_if.wr_data = 32'h0;
    bus_if.wr_be   = 4'h0;
    test_reset();
    test_count();
    test_shadow();
    test_wrap();
    test_partial_write();
    test_compare();
    test_presc();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
